// File: rtl/audio_lerp_resampler.sv
// audio_lerp_resampler: resamples a band-limited input stream onto a local
// output tick by interpolating between the two most recent input samples.
// Define AUDIO_LERP_RESAMPLER_LERP_EN for linear interpolation with a serial
// shift-add multiplier. Leave it undefined for nearest-sample selection.
module audio_lerp_resampler #(
    parameter int IW           = 16,
    parameter int FW           = 16,
    parameter int MCLK_RATE    = 53693175,
    parameter int DATA_CLK_IN  = 300000,
    parameter int DATA_CLK_OUT = 48000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [IW-1:0] data_in,
    input  logic                 in_valid,
    output logic signed [IW-1:0] data_out,
    output logic                 out_valid,
    output logic                 overrun
);

    localparam int DIV_IN_RAW = MCLK_RATE / DATA_CLK_IN;
    localparam int DIV_IN     = (DIV_IN_RAW < 1) ? 1 : DIV_IN_RAW;
    localparam int DIV_OUT    = MCLK_RATE / DATA_CLK_OUT;
    localparam int RECIP      = (2 ** FW) / DIV_IN;
    localparam int EW         = (DIV_IN > 1) ? $clog2(DIV_IN) : 1;
    localparam int CW         = (DIV_OUT > 1) ? $clog2(DIV_OUT) : 1;

    localparam logic [EW-1:0] ELAPSED_MAX = EW'(DIV_IN - 1);
    localparam logic [CW-1:0] TICK_AT     = CW'(DIV_OUT - 1);
    localparam logic [FW-1:0] RECIP_F     = FW'(RECIP);

    logic [CW-1:0]          counter_out;
    logic                   tick;
    logic signed [IW-1:0]   prev;
    logic signed [IW-1:0]   cur;
    logic [EW-1:0]          elapsed;
    logic [FW-1:0]          frac_now;
    logic                   overrun_set;

`ifdef AUDIO_LERP_RESAMPLER_LERP_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`else
    typedef enum logic {S_IDLE, S_DONE} state_t;
`endif

    state_t state;
    state_t next_state;

    assign tick = (counter_out == TICK_AT);

    // elapsed*RECIP stays below 2**FW because elapsed saturates at DIV_IN-1.
    assign frac_now = FW'(elapsed) * RECIP_F;

    // A tick that finds the engine busy is dropped and flagged.
    assign overrun_set = tick && (state != S_IDLE);

    // Output-rate tick counter: 0..DIV_OUT-1, tick on the last count.
    always_ff @(posedge clk) begin
        // NOTE: registered state always uses <= so every flop samples pre-edge values.
        if (reset) begin
            counter_out <= '0;
        end else if (tick) begin
            counter_out <= '0;
        end else begin
            counter_out <= counter_out + CW'(1);
        end
    end

    // Input history: last two samples and the saturating age of the newest.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev    <= '0;
            cur     <= '0;
            elapsed <= '0;
        end else if (in_valid) begin
            prev    <= cur;
            cur     <= data_in;
            elapsed <= '0;
        end else if (elapsed != ELAPSED_MAX) begin
            elapsed <= elapsed + EW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

`ifdef AUDIO_LERP_RESAMPLER_LERP_EN
    localparam int AW = IW + FW + 1;
    localparam int BW = (FW > 1) ? $clog2(FW) : 1;
    localparam logic signed [AW-1:0] ROUND = AW'(2 ** (FW - 1));

    logic signed [IW:0]     diff;
    logic signed [IW-1:0]   op_prev;
    logic signed [AW-1:0]   mcand;
    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   acc_next;
    logic signed [AW-1:0]   rounded;
    logic signed [IW-1:0]   lerp_result;
    logic [FW-1:0]          frac_sh;
    logic [BW-1:0]          bit_cnt;
    logic                   last_bit;

    assign diff        = {cur[IW-1], cur} - {prev[IW-1], prev};
    assign acc_next    = frac_sh[0] ? (acc + mcand) : acc;
    assign rounded     = acc_next + ROUND;
    // The interpolated value lies between prev and cur, so the low IW bits suffice.
    assign lerp_result = op_prev + IW'(rounded >>> FW);
    assign last_bit    = (bit_cnt == BW'(FW - 1));

    // Next-state logic: IDLE -> MUL (FW cycles) -> DONE -> IDLE.
    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            S_IDLE:  if (tick) next_state = S_MUL;
            S_MUL:   if (last_bit) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Operand capture, LSB-first shift-add multiply and output update.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            op_prev   <= '0;
            mcand     <= '0;
            acc       <= '0;
            frac_sh   <= '0;
            bit_cnt   <= '0;
        end else begin
            out_valid <= 1'b0;
            if (overrun_set) begin
                overrun <= 1'b1;
            end
            if (state == S_IDLE && tick) begin
                op_prev <= prev;
                mcand   <= AW'(diff);
                frac_sh <= frac_now;
                acc     <= '0;
                bit_cnt <= '0;
            end else if (state == S_MUL) begin
                acc     <= acc_next;
                mcand   <= mcand <<< 1;
                frac_sh <= frac_sh >> 1;
                bit_cnt <= bit_cnt + BW'(1);
                if (last_bit) begin
                    data_out  <= lerp_result;
                    out_valid <= 1'b1;
                end
            end
        end
    end
`else
    localparam logic [FW-1:0] HALF_F = FW'(2 ** (FW - 1));

    logic signed [IW-1:0] nearest_pick;

    assign nearest_pick = (frac_now < HALF_F) ? prev : cur;

    // Next-state logic: IDLE -> DONE -> IDLE.
    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            S_IDLE:  if (tick) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Nearest-sample selection and output update.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (overrun_set) begin
                overrun <= 1'b1;
            end
            if (state == S_IDLE && tick) begin
                data_out  <= nearest_pick;
                out_valid <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_audio_lerp_resampler.sv
// Self-checking bench for audio_lerp_resampler (both build variants).
module tb_audio_lerp_resampler;

`ifdef AUDIO_LERP_RESAMPLER_LERP_EN
    localparam int LAT      = 17;
    localparam int F_NOUT   = 5;
    localparam int F_GAP    = 20;
    localparam int F_OVR    = 1;
    localparam int EXP_T[6] = '{500, 100, -99, 199, 399, 9};
`else
    localparam int LAT      = 1;
    localparam int F_NOUT   = 11;
    localparam int F_GAP    = 10;
    localparam int F_OVR    = 0;
    localparam int EXP_T[6] = '{0, 100, -100, 200, 400, 7};
`endif
    localparam int DIV_OUT = 1118;

    typedef struct {
        logic signed [15:0] data;
        int                 cyc;
    } exp_t;

    logic               clk;
    logic               reset;
    logic signed [15:0] data_in;
    logic               in_valid;
    logic signed [15:0] data_out;
    logic               out_valid;
    logic               overrun;

    logic               reset_f;
    logic signed [15:0] data_in_f;
    logic               in_valid_f;
    logic signed [15:0] data_out_f;
    logic               out_valid_f;
    logic               overrun_f;

    int   cyc;
    int   cyc_f;
    int   n_assert;
    int   n_fail;
    int   n_out_f;
    int   last_cyc_f;
    int   last_gap_f;
    exp_t sb[$];
    exp_t e;

    audio_lerp_resampler u_dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .data_out  (data_out),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    audio_lerp_resampler #(
        .MCLK_RATE    (1000),
        .DATA_CLK_IN  (100),
        .DATA_CLK_OUT (100)
    ) u_fast (
        .clk       (clk),
        .reset     (reset_f),
        .data_in   (data_in_f),
        .in_valid  (in_valid_f),
        .data_out  (data_out_f),
        .out_valid (out_valid_f),
        .overrun   (overrun_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index since reset release: cycle 0 follows the last reset edge.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        if (reset_f) cyc_f <= 0;
        else         cyc_f <= cyc_f + 1;
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Scoreboard: every out_valid must match the oldest expected entry.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            check("sb_pending", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_data", data_out, e.data);
                check("sb_cycle", cyc, e.cyc);
            end
        end
    end

    // Fast instance: count outputs and the spacing between them.
    always @(negedge clk) begin
        if (!reset_f && out_valid_f === 1'b1) begin
            n_out_f++;
            last_gap_f = cyc_f - last_cyc_f;
            last_cyc_f = cyc_f;
        end
    end

    task automatic goto_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goto_cycle_f(input int c);
        while (cyc_f < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic pulse(input int c, input logic signed [15:0] v);
        goto_cycle(c);
        data_in  = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input logic signed [15:0] v, input int tick_cyc);
        exp_t x;
        x.data = v;
        x.cyc  = tick_cyc + LAT;
        sb.push_back(x);
    endtask

    initial begin
        int pc[10];
        int pv[10];
        pc = '{10, 1027, 1500, 2234, 2600, 3175, 3500, 3800, 4471, 5595};
        pv = '{0, 1000, 100, -100, 100, -100, 0, 200, 400, 7};

        n_assert   = 0;
        n_fail     = 0;
        n_out_f    = 0;
        last_cyc_f = 0;
        last_gap_f = 0;
        reset      = 1'b1;
        data_in    = '0;
        in_valid   = 1'b0;
        reset_f    = 1'b1;
        data_in_f  = '0;
        in_valid_f = 1'b0;

        // Reset, no input: outputs clear, first tick yields 0.
        do_reset();
        check("rst_data_out", data_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_overrun", overrun, 0);
        expect_out(16'sd0, DIV_OUT - 1);
        goto_cycle(DIV_OUT - 1 + LAT + 3);
        check("t1_drain", sb.size(), 0);
        check("t1_hold", data_out, 0);

        // Constant input: every output equals the input.
        do_reset();
        for (int n = 1; n <= 20; n++) expect_out(16'sh1000, n * DIV_OUT - 1);
        for (int c = 1; c < 22380; c += 178) pulse(c, 16'sh1000);
        goto_cycle(20 * DIV_OUT - 1 + LAT + 3);
        check("t2_drain", sb.size(), 0);
        check("t2_overrun", overrun, 0);

        // Directed interpolation points, coincident strobe, strobe mid-compute.
        do_reset();
        for (int n = 0; n < 6; n++) expect_out(16'(EXP_T[n]), (n + 1) * DIV_OUT - 1);
`ifndef AUDIO_LERP_RESAMPLER_LERP_EN
        expect_out(16'sd7, 7 * DIV_OUT - 1);
`endif
        for (int i = 0; i < 10; i++) pulse(pc[i], 16'(pv[i]));
        goto_cycle(7 * DIV_OUT - 1 + 5);
        check("t5_drain", sb.size(), 0);
        check("t5_overrun", overrun, 0);

        // Reset during a computation: no output afterwards, state cleared.
        do_reset();
        check("midrst_data_out", data_out, 0);
        check("midrst_overrun", overrun, 0);
        goto_cycle(40);
        check("midrst_quiet", sb.size(), 0);
        check("midrst_hold", data_out, 0);
        reset = 1'b1;

        // Short output period on the fast instance.
        reset_f = 1'b0;
        goto_cycle_f(18);
        check("f_overrun_pre", overrun_f, 0);
        goto_cycle_f(20);
        check("f_overrun_post", overrun_f, F_OVR);
        goto_cycle_f(115);
        check("f_out_count", n_out_f, F_NOUT);
        check("f_out_gap", last_gap_f, F_GAP);
        check("f_data_out", data_out_f, 0);
        check("f_overrun_sticky", overrun_f, F_OVR);
        reset_f = 1'b1;
        @(posedge clk);
        #1;
        check("f_overrun_rst", overrun_f, 0);
        check("f_out_valid_rst", out_valid_f, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
